// File: rtl/cpu_ctrl_seq_pkg.sv
// Shared definitions for the 8-bit CPU instruction sequencer: opcodes, IR fetch encodings,
// sequencer states and the instruction-length helper.
package cpu8_pkg;

   localparam int OP_W    = 4;
   localparam int FETCH_W = 2;

   localparam logic [OP_W-1:0] OP_NOP = 4'h0;
   localparam logic [OP_W-1:0] OP_LDA = 4'h1;
   localparam logic [OP_W-1:0] OP_STA = 4'h2;
   localparam logic [OP_W-1:0] OP_ADD = 4'h3;
   localparam logic [OP_W-1:0] OP_SUB = 4'h4;
   localparam logic [OP_W-1:0] OP_AND = 4'h5;
   localparam logic [OP_W-1:0] OP_OR  = 4'h6;
   localparam logic [OP_W-1:0] OP_NOT = 4'h7;
   localparam logic [OP_W-1:0] OP_JMP = 4'h9;
   localparam logic [OP_W-1:0] OP_JZ  = 4'hA;
   localparam logic [OP_W-1:0] OP_HLT = 4'hF;

   localparam logic [FETCH_W-1:0] FETCH_HOLD = 2'b00;
   localparam logic [FETCH_W-1:0] FETCH_OP   = 2'b01;
   localparam logic [FETCH_W-1:0] FETCH_ADDR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_F1   = 3'd1,
      ST_DEC  = 3'd2,
      ST_F2   = 3'd3,
      ST_EXEC = 3'd4,
      ST_HLT  = 3'd5
   } state_e;

   // Opcodes followed by an address byte need the extra F2 fetch.
   function automatic logic is_two_byte(input logic [OP_W-1:0] op);
      return (op == OP_LDA) || (op == OP_STA) || (op == OP_JMP) || (op == OP_JZ);
   endfunction

endpackage

// File: rtl/cpu_ctrl_seq_if.sv
// Control bus between the sequencer (master) and the IR/PC/memory/ALU datapath (slave).
// CPU_CTRL_MEM_WAIT_EN adds the mem_ready wait handshake from memory.
interface cpu_ctrl_seq_if #(
   parameter int OP_W    = 4,
   parameter int FETCH_W = 2
);

   logic [OP_W-1:0]    ins;
   logic               zero;
   logic [FETCH_W-1:0] fetch;
   logic               pc_inc;
   logic               pc_load;
   logic               addr_sel;
   logic               mem_rd;
   logic               mem_wr;
   logic               acc_we;
   logic [OP_W-1:0]    alu_op;
   logic               halted;

`ifdef CPU_CTRL_MEM_WAIT_EN
   logic               mem_ready;

   modport master (
      input  ins, zero, mem_ready,
      output fetch, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_we, alu_op, halted
   );

   modport slave (
      output ins, zero, mem_ready,
      input  fetch, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_we, alu_op, halted
   );
`else
   modport master (
      input  ins, zero,
      output fetch, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_we, alu_op, halted
   );

   modport slave (
      output ins, zero,
      input  fetch, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_we, alu_op, halted
   );
`endif

endinterface

// File: rtl/cpu_ctrl_seq_decode.sv
// Combinational decode of sequencer state plus opcode into datapath control strobes.
// mem_ok gates the one-shot actions (fetch, pc_inc, acc_we) of memory cycles.
module cpu_ctrl_decode
   import cpu8_pkg::*;
#(
   parameter int OP_W    = 4,
   parameter int FETCH_W = 2
) (
   input  state_e             state,
   input  logic [OP_W-1:0]    ins,
   input  logic               zero,
   input  logic               mem_ok,
   output logic [FETCH_W-1:0] fetch,
   output logic               pc_inc,
   output logic               pc_load,
   output logic               addr_sel,
   output logic               mem_rd,
   output logic               mem_wr,
   output logic               acc_we,
   output logic [OP_W-1:0]    alu_op,
   output logic               halted
);

   always_comb begin
      fetch    = FETCH_HOLD;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      addr_sel = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      acc_we   = 1'b0;
      alu_op   = '0;
      halted   = 1'b0;

      case (state)
         ST_F1, ST_F2: begin
            mem_rd = 1'b1;
            if (mem_ok) begin
               fetch  = (state == ST_F1) ? FETCH_OP : FETCH_ADDR;
               pc_inc = 1'b1;
            end
         end
         ST_EXEC: begin
            alu_op = ins;
            case (ins)
               OP_LDA: begin
                  mem_rd   = 1'b1;
                  addr_sel = 1'b1;
                  acc_we   = mem_ok;
               end
               OP_STA: begin
                  mem_wr   = 1'b1;
                  addr_sel = 1'b1;
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: acc_we = 1'b1;
               OP_JMP:  pc_load = 1'b1;
               OP_JZ:   pc_load = zero;
               default: ;
            endcase
         end
         ST_HLT:  halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Instruction sequencer: walks each instruction through F1, DEC, (F2), EXEC; HLT is sticky.
// CPU_CTRL_MEM_WAIT_EN stalls memory cycles until the bus mem_ready input is high.
module cpu_ctrl_seq
   import cpu8_pkg::*;
#(
   parameter int              OP_W    = 4,
   parameter int              FETCH_W = 2,
   parameter logic [OP_W-1:0] HALT_OP = 4'hF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   cpu_ctrl_seq_if.master       bus
);

   state_e state_q, state_d;
   logic   mem_ok;
   logic   mem_op;

`ifdef CPU_CTRL_MEM_WAIT_EN
   assign mem_ok = bus.mem_ready;
`else
   assign mem_ok = 1'b1;
`endif

   assign mem_op = (bus.ins == OP_LDA) || (bus.ins == OP_STA);

   // run is only looked at in IDLE and EXEC so an instruction always completes.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (run) state_d = ST_F1;
         ST_F1:   if (mem_ok) state_d = ST_DEC;
         ST_DEC: begin
            if (bus.ins == HALT_OP)         state_d = ST_HLT;
            else if (is_two_byte(bus.ins))  state_d = ST_F2;
            else                            state_d = ST_EXEC;
         end
         ST_F2:   if (mem_ok) state_d = ST_EXEC;
         ST_EXEC: if (mem_ok || !mem_op) state_d = run ? ST_F1 : ST_IDLE;
         ST_HLT:  state_d = ST_HLT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   cpu_ctrl_decode #(
      .OP_W    (OP_W),
      .FETCH_W (FETCH_W)
   ) u_decode (
      .state    (state_q),
      .ins      (bus.ins),
      .zero     (bus.zero),
      .mem_ok   (mem_ok),
      .fetch    (bus.fetch),
      .pc_inc   (bus.pc_inc),
      .pc_load  (bus.pc_load),
      .addr_sel (bus.addr_sel),
      .mem_rd   (bus.mem_rd),
      .mem_wr   (bus.mem_wr),
      .acc_we   (bus.acc_we),
      .alu_op   (bus.alu_op),
      .halted   (bus.halted)
   );

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench for cpu_ctrl_seq: each stimulus cycle queues the hand-derived control vector,
// a negedge monitor pops and compares. CPU_CTRL_MEM_WAIT_EN enables the memory-wait scenario.
module tb_cpu_ctrl_seq;

   logic clk;
   logic rst_n;
   logic run;
   logic mr_tb;

   int total_cnt = 0;
   int bad_cnt   = 0;
   int pc_inc_cnt = 0;

   logic [12:0] exp_q[$];
   string       name_q[$];

   cpu_ctrl_seq_if #(.OP_W(4), .FETCH_W(2)) bus ();

   cpu_ctrl_seq #(.OP_W(4), .FETCH_W(2), .HALT_OP(4'hF)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (run),
      .bus   (bus)
   );

`ifdef CPU_CTRL_MEM_WAIT_EN
   assign bus.mem_ready = mr_tb;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vector layout: {fetch[1:0], pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_we, alu_op[3:0], halted}
   function automatic logic [12:0] mk(input logic [1:0] f, input logic pi, input logic pl,
                                      input logic as, input logic rd, input logic wr,
                                      input logic we, input logic [3:0] op, input logic h);
      return {f, pi, pl, as, rd, wr, we, op, h};
   endfunction

   function automatic logic [12:0] actual();
      return {bus.fetch, bus.pc_inc, bus.pc_load, bus.addr_sel, bus.mem_rd, bus.mem_wr,
              bus.acc_we, bus.alu_op, bus.halted};
   endfunction

   localparam logic [12:0] E_ZERO = 13'd0;

   logic [12:0] e_f1, e_f2, e_hlt;
   initial begin
      e_f1  = mk(2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      e_f2  = mk(2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      e_hlt = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
   end

   task automatic checkOutput(input string name, input logic [12:0] act, input logic [12:0] exp);
      total_cnt++;
      if (act !== exp) begin
         bad_cnt++;
         $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Present one cycle of inputs (at posedge+1), queue the expected outputs, advance a cycle.
   task automatic applyStimulus(input logic r, input logic [3:0] op, input logic z,
                                input logic mr, input logic [12:0] exp, input string name);
      run      = r;
      bus.ins  = op;
      bus.zero = z;
      mr_tb    = mr;
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic [12:0] e;
      logic [12:0] a;
      string       n;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         a = actual();
         checkOutput(n, a, e);
         checkOutput({n, "_excl"},
                     {10'd0, bus.pc_inc & bus.pc_load, bus.mem_rd & bus.mem_wr, bus.fetch == 2'b11},
                     13'd0);
         if (bus.pc_inc) pc_inc_cnt++;
      end
   end

   initial begin
      int pc_snap;
      int waited;
      rst_n    = 1'b0;
      run      = 1'b0;
      bus.ins  = 4'h0;
      bus.zero = 1'b0;
      mr_tb    = 1'b1;
      #3;
      checkOutput("reset_outputs", actual(), E_ZERO);
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ADD: IDLE, F1, DEC, EXEC, back to F1
      applyStimulus(1, 4'h0, 0, 1, E_ZERO, "add_idle");
      applyStimulus(1, 4'h0, 0, 1, e_f1, "add_f1");
      applyStimulus(1, 4'h3, 0, 1, E_ZERO, "add_dec");
      applyStimulus(1, 4'h3, 0, 1, mk(2'b00, 0, 0, 0, 0, 0, 1, 4'h3, 0), "add_exec");

      // LDA: four cycles, two PC increments
      pc_snap = pc_inc_cnt;
      applyStimulus(1, 4'h0, 0, 1, e_f1, "lda_f1");
      applyStimulus(1, 4'h1, 0, 1, E_ZERO, "lda_dec");
      applyStimulus(1, 4'h1, 0, 1, e_f2, "lda_f2");
      applyStimulus(1, 4'h1, 0, 1, mk(2'b00, 0, 0, 1, 1, 0, 1, 4'h1, 0), "lda_exec");
      checkOutput("lda_pc_adv", 13'(pc_inc_cnt - pc_snap), 13'd2);

      // JZ not taken
      applyStimulus(1, 4'h0, 0, 1, e_f1, "jz0_f1");
      applyStimulus(1, 4'hA, 0, 1, E_ZERO, "jz0_dec");
      applyStimulus(1, 4'hA, 0, 1, e_f2, "jz0_f2");
      applyStimulus(1, 4'hA, 0, 1, mk(2'b00, 0, 0, 0, 0, 0, 0, 4'hA, 0), "jz0_exec");

      // JZ taken: pc_load for exactly the EXEC cycle
      applyStimulus(1, 4'h0, 1, 1, e_f1, "jz1_f1");
      applyStimulus(1, 4'hA, 1, 1, E_ZERO, "jz1_dec");
      applyStimulus(1, 4'hA, 1, 1, e_f2, "jz1_f2");
      applyStimulus(1, 4'hA, 1, 1, mk(2'b00, 0, 1, 0, 0, 0, 0, 4'hA, 0), "jz1_exec");

      // JMP, then STA with run dropped during F2
      applyStimulus(1, 4'h0, 0, 1, e_f1, "jmp_f1");
      applyStimulus(1, 4'h9, 0, 1, E_ZERO, "jmp_dec");
      applyStimulus(1, 4'h9, 0, 1, e_f2, "jmp_f2");
      applyStimulus(1, 4'h9, 0, 1, mk(2'b00, 0, 1, 0, 0, 0, 0, 4'h9, 0), "jmp_exec");
      applyStimulus(1, 4'h0, 0, 1, e_f1, "sta_f1");
      applyStimulus(1, 4'h2, 0, 1, E_ZERO, "sta_dec");
      applyStimulus(0, 4'h2, 0, 1, e_f2, "sta_f2");
      applyStimulus(0, 4'h2, 0, 1, mk(2'b00, 0, 0, 1, 0, 1, 0, 4'h2, 0), "sta_exec");
      applyStimulus(0, 4'h2, 0, 1, E_ZERO, "sta_idle0");
      applyStimulus(0, 4'h2, 0, 1, E_ZERO, "sta_idle1");

      // Reserved opcode 8 behaves as a single-byte NOP
      applyStimulus(1, 4'h0, 0, 1, E_ZERO, "rsv_idle");
      applyStimulus(0, 4'h0, 0, 1, e_f1, "rsv_f1");
      applyStimulus(0, 4'h8, 0, 1, E_ZERO, "rsv_dec");
      applyStimulus(0, 4'h8, 0, 1, mk(2'b00, 0, 0, 0, 0, 0, 0, 4'h8, 0), "rsv_exec");
      applyStimulus(0, 4'h8, 0, 1, E_ZERO, "rsv_idle_after");

`ifdef CPU_CTRL_MEM_WAIT_EN
      // F1 stalled three cycles, then an LDA whose EXEC waits one cycle
      applyStimulus(1, 4'h0, 0, 1, E_ZERO, "mw_idle");
      for (int i = 0; i < 3; i++)
         applyStimulus(1, 4'h0, 0, 0, mk(2'b00, 0, 0, 0, 1, 0, 0, 4'h0, 0), $sformatf("mw_f1_wait%0d", i));
      applyStimulus(1, 4'h0, 0, 1, e_f1, "mw_f1_go");
      applyStimulus(1, 4'h1, 0, 1, E_ZERO, "mw_dec");
      applyStimulus(1, 4'h1, 0, 1, e_f2, "mw_f2");
      applyStimulus(0, 4'h1, 0, 0, mk(2'b00, 0, 0, 1, 1, 0, 0, 4'h1, 0), "mw_lda_wait");
      applyStimulus(0, 4'h1, 0, 1, mk(2'b00, 0, 0, 1, 1, 0, 1, 4'h1, 0), "mw_lda_go");
      applyStimulus(0, 4'h1, 0, 1, E_ZERO, "mw_idle_after");
`endif

      // HLT: sticky for 20 cycles with run held high
      applyStimulus(1, 4'h0, 0, 1, E_ZERO, "hlt_idle");
      applyStimulus(1, 4'h0, 0, 1, e_f1, "hlt_f1");
      applyStimulus(1, 4'hF, 0, 1, E_ZERO, "hlt_dec");
      for (int i = 0; i < 20; i++)
         applyStimulus(1, 4'hF, 0, 1, e_hlt, $sformatf("hlt_hold%0d", i));

      // Asynchronous reset clears halted between clock edges
      #2;
      run   = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", actual(), E_ZERO);
      @(posedge clk);
      #2;
      checkOutput("reset_held", actual(), E_ZERO);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(0, 4'hF, 0, 1, E_ZERO, "post_reset_idle");

      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(posedge clk);
         waited++;
      end
      if (exp_q.size() > 0) begin
         total_cnt++;
         bad_cnt++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
